// File: rtl/branch_redirect_if.sv
// Branch-resolution request and redirect/flush response bundle between the
// execute stage (master) and the redirect unit (slave).
interface branch_redirect_if #(
  parameter int WIDTH = 32
);
  logic             Stall;
  logic             BranchValid;
  logic             Taken;
  logic             BranchMux_signal;
  logic [WIDTH-1:0] ALUResult_out;
  logic [WIDTH-1:0] ReadData1;
  logic             Redirect;
  logic [WIDTH-1:0] RedirectTarget;
  logic             Flush;
  logic             MisalignErr;
  logic             Busy;
  logic [15:0]      RedirectCount;

  modport master (
    output Stall, BranchValid, Taken, BranchMux_signal, ALUResult_out, ReadData1,
    input  Redirect, RedirectTarget, Flush, MisalignErr, Busy, RedirectCount
  );

  modport slave (
    input  Stall, BranchValid, Taken, BranchMux_signal, ALUResult_out, ReadData1,
    output Redirect, RedirectTarget, Flush, MisalignErr, Busy, RedirectCount
  );
endinterface

// File: rtl/branch_redirect_unit.sv
// Turns a resolved taken branch into a one-cycle PC redirect plus a fixed-length
// flush window; misaligned targets raise MisalignErr instead of redirecting.
module branch_redirect_unit #(
  parameter int WIDTH        = 32,
  parameter int FLUSH_CYCLES = 2,
  parameter int ALIGN_BITS   = 2
) (
  input  logic               Clk,
  input  logic               Reset,
  branch_redirect_if.slave   bus
);
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_FLUSH = 1'b1;

  localparam logic [2:0]       FLUSH_LOAD = 3'(FLUSH_CYCLES);
  localparam logic [WIDTH-1:0] ALIGN_MASK = WIDTH'((64'd1 << ALIGN_BITS) - 64'd1);

  logic [0:0]       state_q, state_d;
  logic [2:0]       fcnt_q, fcnt_d;
  logic             redirect_q, redirect_d;
  logic             flush_q, flush_d;
  logic             misalign_q, misalign_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] target_q, target_d;
  logic [15:0]      redirect_cnt_q, redirect_cnt_d;

  logic [WIDTH-1:0] tgt;
  logic             accept;
  logic             misaligned;

  assign tgt        = bus.BranchMux_signal ? bus.ALUResult_out : bus.ReadData1;
  assign accept     = bus.BranchValid && !bus.Stall && (state_q == S_IDLE);
  assign misaligned = |(tgt & ALIGN_MASK);

  always_comb begin
    state_d        = state_q;
    fcnt_d         = fcnt_q;
    redirect_d     = 1'b0;
    misalign_d     = 1'b0;
    flush_d        = flush_q;
    target_d       = target_q;
    redirect_cnt_d = redirect_cnt_q;
    unique case (state_q)
      S_IDLE: begin
        flush_d = 1'b0;
        if (accept && bus.Taken) begin
          if (misaligned) begin
            misalign_d = 1'b1;
          end else begin
            state_d    = S_FLUSH;
            fcnt_d     = FLUSH_LOAD;
            redirect_d = 1'b1;
            flush_d    = 1'b1;
            target_d   = tgt;
            if (redirect_cnt_q != 16'hFFFF) redirect_cnt_d = redirect_cnt_q + 16'd1;
          end
        end
      end
      S_FLUSH: begin
        // Free-running window: Stall and wrong-path branches are ignored here.
        if (fcnt_q <= 3'd1) begin
          state_d = S_IDLE;
          fcnt_d  = 3'd0;
          flush_d = 1'b0;
        end else begin
          fcnt_d  = fcnt_q - 3'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
        fcnt_d  = 3'd0;
        flush_d = 1'b0;
      end
    endcase
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q        <= S_IDLE;
      fcnt_q         <= 3'd0;
      redirect_q     <= 1'b0;
      flush_q        <= 1'b0;
      misalign_q     <= 1'b0;
      busy_q         <= 1'b0;
      target_q       <= '0;
      redirect_cnt_q <= 16'd0;
    end else begin
      state_q        <= state_d;
      fcnt_q         <= fcnt_d;
      redirect_q     <= redirect_d;
      flush_q        <= flush_d;
      misalign_q     <= misalign_d;
      busy_q         <= busy_d;
      target_q       <= target_d;
      redirect_cnt_q <= redirect_cnt_d;
    end
  end

  assign bus.Redirect       = redirect_q;
  assign bus.RedirectTarget = target_q;
  assign bus.Flush          = flush_q;
  assign bus.MisalignErr    = misalign_q;
  assign bus.Busy           = busy_q;
  assign bus.RedirectCount  = redirect_cnt_q;
endmodule

// File: tb/tb_branch_redirect_unit.sv
// Directed checks of redirect timing, flush window, misalign, stall and reset.
module tb_branch_redirect_unit;
  logic Clk = 1'b0;
  logic Reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  branch_redirect_if #(.WIDTH(32)) bus ();

  branch_redirect_unit #(.WIDTH(32), .FLUSH_CYCLES(2), .ALIGN_BITS(2)) dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  task automatic tick();
    @(posedge Clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic tk, input logic sel,
                       input logic [31:0] alu, input logic [31:0] rd1);
    bus.BranchValid      = bv;
    bus.Taken            = tk;
    bus.BranchMux_signal = sel;
    bus.ALUResult_out    = alu;
    bus.ReadData1        = rd1;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
  endtask

  task automatic test_reset();
    bus.Stall = 1'b0;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_0100, 32'h0);
    Reset = 1'b1;
    tick();
    tick();
    Reset = 1'b0;
    idle();
    tests++; if (bus.Redirect !== 1'b0) begin fails++; $display("FAIL reset_redirect got %b want 0", bus.Redirect); end
    tests++; if (bus.Flush !== 1'b0) begin fails++; $display("FAIL reset_flush got %b want 0", bus.Flush); end
    tests++; if (bus.MisalignErr !== 1'b0) begin fails++; $display("FAIL reset_misalign got %b want 0", bus.MisalignErr); end
    tests++; if (bus.Busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", bus.Busy); end
    tests++; if (bus.RedirectTarget !== 32'h0) begin fails++; $display("FAIL reset_target got %h want 0", bus.RedirectTarget); end
    tests++; if (bus.RedirectCount !== 16'h0) begin fails++; $display("FAIL reset_count got %h want 0", bus.RedirectCount); end
  endtask

  task automatic test_aligned_redirect();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1040, 32'hDEAD_0000);
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b1) begin fails++; $display("FAIL alu_redirect got %b want 1", bus.Redirect); end
    tests++; if (bus.RedirectTarget !== 32'h0000_1040) begin fails++; $display("FAIL alu_target got %h want 00001040", bus.RedirectTarget); end
    tests++; if (bus.Flush !== 1'b1 || bus.Busy !== 1'b1) begin fails++; $display("FAIL alu_flush1 got flush=%b busy=%b want 1 1", bus.Flush, bus.Busy); end
    tests++; if (bus.RedirectCount !== 16'd1) begin fails++; $display("FAIL alu_count got %0d want 1", bus.RedirectCount); end
    tick();
    tests++; if (bus.Redirect !== 1'b0 || bus.Flush !== 1'b1) begin fails++; $display("FAIL alu_flush2 got redirect=%b flush=%b want 0 1", bus.Redirect, bus.Flush); end
    tick();
    tests++; if (bus.Flush !== 1'b0 || bus.Busy !== 1'b0) begin fails++; $display("FAIL alu_flush_end got flush=%b busy=%b want 0 0", bus.Flush, bus.Busy); end
    tests++; if (bus.RedirectTarget !== 32'h0000_1040) begin fails++; $display("FAIL alu_target_hold got %h want 00001040", bus.RedirectTarget); end
  endtask

  task automatic test_readdata_target();
    drive(1'b1, 1'b1, 1'b0, 32'h1234_5670, 32'hFFFF_FFFC);
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectTarget !== 32'hFFFF_FFFC) begin fails++; $display("FAIL rd1_target got redirect=%b target=%h want 1 FFFFFFFC", bus.Redirect, bus.RedirectTarget); end
    tests++; if (bus.RedirectCount !== 16'd2) begin fails++; $display("FAIL rd1_count got %0d want 2", bus.RedirectCount); end
    tick();
    tick();
  endtask

  task automatic test_not_taken();
    drive(1'b1, 1'b0, 1'b1, 32'h0000_2000, 32'h0);
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b0 || bus.Flush !== 1'b0 || bus.MisalignErr !== 1'b0) begin fails++; $display("FAIL not_taken got redirect=%b flush=%b mis=%b want 0 0 0", bus.Redirect, bus.Flush, bus.MisalignErr); end
    tests++; if (bus.RedirectTarget !== 32'hFFFF_FFFC || bus.RedirectCount !== 16'd2) begin fails++; $display("FAIL not_taken_hold got target=%h count=%0d want FFFFFFFC 2", bus.RedirectTarget, bus.RedirectCount); end
  endtask

  task automatic test_misalign();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_1042, 32'h0);
    tick();
    idle();
    tests++; if (bus.MisalignErr !== 1'b1) begin fails++; $display("FAIL misalign_pulse got %b want 1", bus.MisalignErr); end
    tests++; if (bus.Redirect !== 1'b0 || bus.Flush !== 1'b0 || bus.Busy !== 1'b0) begin fails++; $display("FAIL misalign_quiet got redirect=%b flush=%b busy=%b want 0 0 0", bus.Redirect, bus.Flush, bus.Busy); end
    tests++; if (bus.RedirectCount !== 16'd2 || bus.RedirectTarget !== 32'hFFFF_FFFC) begin fails++; $display("FAIL misalign_hold got count=%0d target=%h want 2 FFFFFFFC", bus.RedirectCount, bus.RedirectTarget); end
    tick();
    tests++; if (bus.MisalignErr !== 1'b0) begin fails++; $display("FAIL misalign_one_cycle got %b want 0", bus.MisalignErr); end
  endtask

  task automatic test_wrong_path();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_3000, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_4002, 32'h0);
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectCount !== 16'd3) begin fails++; $display("FAIL wp_first got redirect=%b count=%0d want 1 3", bus.Redirect, bus.RedirectCount); end
    tick();
    tests++; if (bus.Redirect !== 1'b0 || bus.MisalignErr !== 1'b0 || bus.Flush !== 1'b1) begin fails++; $display("FAIL wp_drop1 got redirect=%b mis=%b flush=%b want 0 0 1", bus.Redirect, bus.MisalignErr, bus.Flush); end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_4000, 32'h0);
    tick();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_5000, 32'h0);
    tests++; if (bus.Redirect !== 1'b0 || bus.Flush !== 1'b0 || bus.RedirectTarget !== 32'h0000_3000) begin fails++; $display("FAIL wp_drop2 got redirect=%b flush=%b target=%h want 0 0 00003000", bus.Redirect, bus.Flush, bus.RedirectTarget); end
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectTarget !== 32'h0000_5000 || bus.RedirectCount !== 16'd4) begin fails++; $display("FAIL wp_accept_after got redirect=%b target=%h count=%0d want 1 00005000 4", bus.Redirect, bus.RedirectTarget, bus.RedirectCount); end
    tick();
    tick();
  endtask

  task automatic test_stall();
    bus.Stall = 1'b1;
    drive(1'b1, 1'b1, 1'b1, 32'h0000_6000, 32'h0);
    tick();
    tests++; if (bus.Redirect !== 1'b0 || bus.Flush !== 1'b0 || bus.RedirectCount !== 16'd4) begin fails++; $display("FAIL stall_ignore got redirect=%b flush=%b count=%0d want 0 0 4", bus.Redirect, bus.Flush, bus.RedirectCount); end
    bus.Stall = 1'b0;
    tick();
    idle();
    bus.Stall = 1'b1;
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectTarget !== 32'h0000_6000) begin fails++; $display("FAIL stall_release got redirect=%b target=%h want 1 00006000", bus.Redirect, bus.RedirectTarget); end
    tick();
    tests++; if (bus.Flush !== 1'b1) begin fails++; $display("FAIL stall_flush2 got %b want 1", bus.Flush); end
    tick();
    tests++; if (bus.Flush !== 1'b0 || bus.Busy !== 1'b0) begin fails++; $display("FAIL stall_flush_end got flush=%b busy=%b want 0 0", bus.Flush, bus.Busy); end
    bus.Stall = 1'b0;
  endtask

  task automatic test_reset_mid_flush();
    drive(1'b1, 1'b1, 1'b1, 32'h0000_7000, 32'h0);
    tick();
    idle();
    tick();
    Reset = 1'b1;
    tick();
    tests++; if (bus.Flush !== 1'b0 || bus.RedirectCount !== 16'd0 || bus.Busy !== 1'b0) begin fails++; $display("FAIL rst_flush2 got flush=%b count=%0d busy=%b want 0 0 0", bus.Flush, bus.RedirectCount, bus.Busy); end
    drive(1'b1, 1'b1, 1'b1, 32'h0000_7100, 32'h0);
    tick();
    tests++; if (bus.Redirect !== 1'b0 || bus.RedirectTarget !== 32'h0) begin fails++; $display("FAIL rst_priority got redirect=%b target=%h want 0 0", bus.Redirect, bus.RedirectTarget); end
    Reset = 1'b0;
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectCount !== 16'd1) begin fails++; $display("FAIL rst_then_accept got redirect=%b count=%0d want 1 1", bus.Redirect, bus.RedirectCount); end
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tests++; if (bus.Flush !== 1'b0 || bus.Redirect !== 1'b0) begin fails++; $display("FAIL rst_flush1 got flush=%b redirect=%b want 0 0", bus.Flush, bus.Redirect); end
    drive(1'b1, 1'b1, 1'b0, 32'h0, 32'h0000_8000);
    tick();
    idle();
    tests++; if (bus.Redirect !== 1'b1 || bus.RedirectTarget !== 32'h0000_8000) begin fails++; $display("FAIL rst_no_pending got redirect=%b target=%h want 1 00008000", bus.Redirect, bus.RedirectTarget); end
    tick();
    tick();
  endtask

  task automatic test_saturate();
    force dut.redirect_cnt_q = 16'hFFFD;
    tick();
    release dut.redirect_cnt_q;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 1'b1, 32'h0000_9000 + 32'(i * 16), 32'h0);
      tick();
      idle();
      tests++;
      if (bus.Redirect !== 1'b1 || bus.RedirectCount !== ((i == 0) ? 16'hFFFE : 16'hFFFF)) begin
        fails++;
        $display("FAIL sat_%0d got redirect=%b count=%h want 1 %h", i, bus.Redirect, bus.RedirectCount, (i == 0) ? 16'hFFFE : 16'hFFFF);
      end
      tick();
      tick();
    end
  endtask

  initial begin
    bus.Stall = 1'b0;
    idle();
    test_reset();
    test_aligned_redirect();
    test_readdata_target();
    test_not_taken();
    test_misalign();
    test_wrong_path();
    test_stall();
    test_reset_mid_flush();
    test_saturate();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/branch_redirect_unit.md
BRANCH_REDIRECT_UNIT -- requirements
Module: branch_redirect_unit

Interface
REQ-001 Parameter WIDTH, default 32, SHALL set the width of target operands and RedirectTarget.
REQ-002 Parameter FLUSH_CYCLES, default 2, legal range 1..4, SHALL set how many cycles Flush is asserted per redirect.
REQ-003 Parameter ALIGN_BITS, default 2, legal range 0..3, SHALL set how many low target bits must be zero for a legal redirect.
REQ-004 The block SHALL use one clock; reset is synchronous and active-high.
REQ-005 Clk  input  1  rising-edge clock.
REQ-006 Reset  input  1  synchronous active-high reset.
REQ-007 Stall  input  1  pipeline stall; a resolving branch is not sampled while high.
REQ-008 BranchValid  input  1  a branch/jump resolves this cycle.
REQ-009 Taken  input  1  resolved direction; 1 = redirect required.
REQ-010 BranchMux_signal  input  1  target source select; 1 = ALUResult_out, 0 = ReadData1.
REQ-011 ALUResult_out  input  WIDTH  computed branch target.
REQ-012 ReadData1  input  WIDTH  register jump target.
REQ-013 Redirect  output  1  one-cycle pulse requesting a PC load.
REQ-014 RedirectTarget  output  WIDTH  registered target, valid while Redirect = 1 and held until the next redirect.
REQ-015 Flush  output  1  squash younger pipeline stages.
REQ-016 MisalignErr  output  1  one-cycle pulse when a taken target is misaligned.
REQ-017 Busy  output  1  high whenever state is not IDLE.
REQ-018 RedirectCount  output  16  saturating count of redirects issued.

Function
REQ-019 Accept condition SHALL be BranchValid=1 and Stall=0 and state IDLE; BranchValid in any other cycle SHALL be ignored.
REQ-020 On accept, the selected target SHALL be ALUResult_out when BranchMux_signal=1, else ReadData1, all WIDTH bits preserved; no 1-bit truncation is permitted.
REQ-021 Accept with Taken=0 SHALL cause no output change.
REQ-022 Accept with Taken=1 and the low ALIGN_BITS bits of the target all zero SHALL, in the next cycle, drive Redirect=1, RedirectTarget=target and Flush=1, and move state IDLE->FLUSH.
REQ-023 Accept with Taken=1 and any of the low ALIGN_BITS bits nonzero SHALL pulse MisalignErr for one cycle in the next cycle, leave Redirect, Flush, RedirectTarget and RedirectCount unchanged, and keep state IDLE.
REQ-024 States SHALL be IDLE and FLUSH; a down-counter SHALL be loaded with FLUSH_CYCLES on entry to FLUSH.
REQ-025 Flush SHALL be 1 for exactly FLUSH_CYCLES consecutive cycles starting with the Redirect cycle; FLUSH->IDLE follows the last of these cycles.
REQ-026 Redirect SHALL be 1 only in the first FLUSH cycle.
REQ-027 Stall SHALL NOT extend or pause the flush window.
REQ-028 BranchValid during FLUSH (wrong-path) SHALL be dropped with no redirect and no MisalignErr; a branch in the cycle after the last Flush cycle SHALL be accepted.
REQ-029 RedirectCount SHALL increment by 1 per Redirect pulse and saturate at 16'hFFFF.
REQ-030 All outputs SHALL be registered; latency from accept to Redirect/MisalignErr is exactly 1 cycle.

Reset
REQ-031 Reset=1 at a clock edge SHALL set state IDLE, flush counter 0, Redirect=0, Flush=0, MisalignErr=0, Busy=0, RedirectTarget=0 and RedirectCount=0.
REQ-032 Reset SHALL take priority over any accept, including a branch sampled in the same cycle.
REQ-033 Reset asserted mid-FLUSH SHALL deassert Flush at the next edge, with no pending redirect retained.

Verification
REQ-034 WIDTH=32, FLUSH_CYCLES=2: accept with Taken=1, sel=1, ALUResult_out=32'h0000_1040 -> next cycle Redirect=1, RedirectTarget=32'h0000_1040, Flush=1 for 2 cycles, RedirectCount=1.
REQ-035 Accept with Taken=1, sel=0, ReadData1=32'hFFFF_FFFC -> RedirectTarget=32'hFFFF_FFFC with all upper bits intact.
REQ-036 Accept with Taken=1, ALUResult_out=32'h0000_1042 -> MisalignErr pulse of 1 cycle, Redirect=0, Flush=0, RedirectCount unchanged.
REQ-037 Redirect followed by BranchValid=1, Taken=1 in both Flush cycles -> both ignored; a branch one cycle later is accepted and produces Redirect.
REQ-038 BranchValid=1, Taken=1 with Stall=1 -> no response; Stall applied during Flush -> Flush still ends after exactly 2 cycles.
REQ-039 Reset pulsed in the second Flush cycle -> Flush=0 and RedirectCount=0 at the next edge; force 65535 redirects, then one more -> RedirectCount holds 16'hFFFF.
